// File: rtl/seg7_scan.sv
// Eight-digit multiplexed hex driver for a common-anode seven-segment display.
// NUMB is snapshotted at each frame start so a frame never mixes old and new digits.
module seg7_scan #(
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] NUMB,
  input  logic        blank_en,
  input  logic [7:0]  dp_mask,
  output logic [7:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP
);

  localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_tick_cnt;
  logic [2:0]       r_idx;
  logic [31:0]      r_snap;

  logic [4:0] w_shamt;
  logic [3:0] w_nib;
  logic       w_blank;
  logic       w_frame_start;
  logic [6:0] w_seg;
  logic [7:0] w_an_dec;

  assign w_shamt       = {r_idx, 2'b00};
  assign w_nib         = r_snap[w_shamt +: 4];
  assign w_frame_start = (r_tick_cnt == '0) && (r_idx == 3'd0);
  assign w_an_dec      = ~(8'd1 << r_idx);

  // A digit is blanked when it and every more-significant nibble are zero.
  assign w_blank = blank_en && (r_idx != 3'd0) && ((r_snap >> w_shamt) == 32'd0);

  // Hex glyphs, active-low {g,f,e,d,c,b,a}.
  always_comb begin
    w_seg = 7'h7F;
    case (w_nib)
      4'h0: w_seg = 7'h40;
      4'h1: w_seg = 7'h79;
      4'h2: w_seg = 7'h24;
      4'h3: w_seg = 7'h30;
      4'h4: w_seg = 7'h19;
      4'h5: w_seg = 7'h12;
      4'h6: w_seg = 7'h02;
      4'h7: w_seg = 7'h78;
      4'h8: w_seg = 7'h00;
      4'h9: w_seg = 7'h10;
      4'hA: w_seg = 7'h08;
      4'hB: w_seg = 7'h03;
      4'hC: w_seg = 7'h46;
      4'hD: w_seg = 7'h21;
      4'hE: w_seg = 7'h06;
      4'hF: w_seg = 7'h0E;
      default: w_seg = 7'h7F;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick_cnt <= '0;
      r_idx      <= 3'd0;
      r_snap     <= 32'd0;
      AN         <= 8'hFF;
      SEG        <= 7'h7F;
      DP         <= 1'b1;
    end else begin
      if (r_tick_cnt == TICK_LAST) begin
        r_tick_cnt <= '0;
        r_idx      <= r_idx + 3'd1;
      end else begin
        r_tick_cnt <= r_tick_cnt + CNT_W'(1);
      end
      if (w_frame_start) begin
        r_snap <= NUMB;
      end
      // Outputs decode the pre-edge digit index and snapshot.
      AN  <= w_blank ? 8'hFF : w_an_dec;
      SEG <= w_seg;
      DP  <= w_blank | ~dp_mask[r_idx];
    end
  end

endmodule
